// File: rtl/tr_pkg.sv
// Shared tuner package: step-generator state encodings and default widths,
// also imported by the manual-mode FSM.
package tr_pkg;

  localparam int WIDTH_MANUAL_DEF = 16;
  localparam int HP_WIDTH_DEF     = 16;
  localparam int DIR_SETUP_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } tr_step_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tr_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle
// increment; shared by the tuner's pulse counters.
module tr_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tr_step_gen.sv
// Step/direction pulse generator for the motor driver: symmetric step pulses
// of programmable half-period with a direction setup gap before each reversal.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | not running, step low, busy low
// ST_SETUP | dir_out just updated, step held low for DIR_SETUP clocks
// ST_HIGH  | step high for max(half_period,1) clocks
// ST_LOW   | step low for max(half_period,1) clocks, then decide next
module tr_step_gen
  import tr_pkg::*;
#(
  parameter int WIDTH_MANUAL = WIDTH_MANUAL_DEF,
  parameter int HP_WIDTH     = HP_WIDTH_DEF,
  parameter int DIR_SETUP    = DIR_SETUP_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      dir,
  input  logic [HP_WIDTH-1:0]       half_period,
  input  logic                      clr_count,
  output logic                      step,
  output logic                      dir_out,
  output logic [2*WIDTH_MANUAL-1:0] count_N,
  output logic                      busy
);

  localparam int DS_LOAD = (DIR_SETUP > 1) ? DIR_SETUP - 1 : 0;
  localparam int TMR_W   = max_int(HP_WIDTH, $clog2(DIR_SETUP + 1));

  tr_step_state_e   state_q;
  logic [TMR_W-1:0] timer_q;
  logic             step_q;
  logic             dir_out_q;
  logic             busy_q;

  logic [TMR_W-1:0] hp_load;
  logic             tmr_done;
  logic             dir_chg;
  logic             enter_high;

  // Timer holds "clocks remaining minus one", so a zero half-period loads 0 like 1 does.
  assign hp_load    = (half_period == '0) ? '0 : TMR_W'(half_period - 1'b1);
  assign tmr_done   = (timer_q == '0);
  assign dir_chg    = (dir != dir_out_q);
  assign enter_high = enable &&
                      (((state_q == ST_IDLE)  && !dir_chg) ||
                       ((state_q == ST_SETUP) && tmr_done) ||
                       ((state_q == ST_LOW)   && tmr_done && !dir_chg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      step_q    <= 1'b0;
      dir_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            busy_q <= 1'b1;
            if (dir_chg) begin
              state_q   <= ST_SETUP;
              dir_out_q <= dir;
              timer_q   <= TMR_W'(DS_LOAD);
            end else begin
              state_q <= ST_HIGH;
              step_q  <= 1'b1;
              timer_q <= hp_load;
            end
          end
        end
        ST_SETUP: begin
          if (!tmr_done) begin
            timer_q <= timer_q - TMR_W'(1);
          end else if (enable) begin
            state_q <= ST_HIGH;
            step_q  <= 1'b1;
            timer_q <= hp_load;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        // Enable is deliberately ignored here so a started pulse always completes.
        ST_HIGH: begin
          if (!tmr_done) begin
            timer_q <= timer_q - TMR_W'(1);
          end else begin
            state_q <= ST_LOW;
            step_q  <= 1'b0;
            timer_q <= hp_load;
          end
        end
        ST_LOW: begin
          if (!tmr_done) begin
            timer_q <= timer_q - TMR_W'(1);
          end else if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (dir_chg) begin
            state_q   <= ST_SETUP;
            dir_out_q <= dir;
            timer_q   <= TMR_W'(DS_LOAD);
          end else begin
            state_q <= ST_HIGH;
            step_q  <= 1'b1;
            timer_q <= hp_load;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= 1'b0;
          busy_q  <= 1'b0;
          timer_q <= '0;
        end
      endcase
    end
  end

  tr_sat_counter #(
    .WIDTH(2*WIDTH_MANUAL)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (enter_high),
    .clr   (clr_count),
    .count (count_N)
  );

  assign step    = step_q;
  assign dir_out = dir_out_q;
  assign busy    = busy_q;

endmodule

// File: doc/tr_step_gen.md
TR_STEP_GEN -- requirements
Module: tr_step_gen

Interface
REQ-001 SHALL have parameter WIDTH_MANUAL, default 16, setting count width to 2*WIDTH_MANUAL.
REQ-002 SHALL have parameter HP_WIDTH, default 16, the width of the half-period field.
REQ-003 SHALL have parameter DIR_SETUP, default 8, the clocks from a direction change to the next step rising edge.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  motor run enable from manual-mode FSM; level, 1 = generate steps.
REQ-007 dir  input  1  requested direction.
REQ-008 half_period  input  HP_WIDTH  clocks per step high phase and per step low phase.
REQ-009 clr_count  input  1  synchronous pulse that clears count_N.
REQ-010 step  output  1  step pulse to motor driver, registered.
REQ-011 dir_out  output  1  direction to motor driver, registered.
REQ-012 count_N  output  2*WIDTH_MANUAL  number of step rising edges generated since the last clear.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, SETUP, HIGH and LOW, with one state register and one phase-timer register.
REQ-015 IDLE: step=0; on enable=1, if dir differs from dir_out go to SETUP, otherwise go to HIGH on the next clock.
REQ-016 SETUP: dir_out <= dir on entry; step=0; after DIR_SETUP clocks go to HIGH, or to IDLE if enable=0 at expiry.
REQ-017 HIGH: step=1 for exactly max(half_period,1) clocks, then go to LOW; enable falling mid-phase SHALL NOT shorten the phase.
REQ-018 LOW: step=0 for max(half_period,1) clocks; at expiry, enable=0 -> IDLE, dir change -> SETUP, else -> HIGH.
REQ-019 half_period SHALL be sampled once on entry to each HIGH or LOW phase; later changes apply from the next phase.
REQ-020 A half_period of 0 SHALL be treated as 1, giving a step period of 2 clocks minimum.
REQ-021 count_N SHALL increment by 1 on the clock that enters HIGH.
REQ-022 count_N SHALL saturate at all-ones (no wrap-around).
REQ-023 clr_count SHALL take priority over a same-cycle increment, giving count_N=0.
REQ-024 dir_out SHALL change only on entry to SETUP, never in HIGH or LOW.
REQ-025 Latency: with enable rising at cycle t from IDLE and no direction change, step SHALL be 1 at cycle t+1.
REQ-026 busy SHALL be registered and consistent with the state in the same cycle.

Reset
REQ-027 Reset assertion SHALL force, asynchronously and including mid-pulse, state=IDLE, step=0, dir_out=0, count_N=0, busy=0 and the phase timer to 0.
REQ-028 After reset deassertion, the block SHALL act only on enable sampled at the first clock edge.

Structure
REQ-029 State encodings, WIDTH_MANUAL and HP_WIDTH defaults SHALL live in the shared tuner package (tr_pkg), also used by the manual-mode FSM.
REQ-030 The saturating counter SHALL be the sub-module tr_sat_counter (inputs inc and clr; clr dominant), so that other pulse counters can reuse it.
REQ-031 All logic SHALL be synchronous to clk, except the asynchronous reset.

Verification
REQ-032 Basic run: half_period=3, dir=0, enable high 20 clocks -> step 3 high / 3 low starting 1 clock after enable; count_N=4; busy drops after the LOW phase.
REQ-033 Direction change: dir toggles while running, DIR_SETUP=8 -> current LOW completes, dir_out toggles, step stays low 8 clocks, then HIGH.
REQ-034 Early stop: enable drops 1 clock into HIGH, half_period=5 -> step high the full 5 clocks, low 5 clocks, then IDLE.
REQ-035 Saturation and clear: count_N preloaded to all-ones via force, one more step -> count_N stays all-ones; clr_count with an increment in the same cycle -> 0.
REQ-036 Zero period: half_period=0 -> step period of 2 clocks, 1 high / 1 low.
REQ-037 Mid-pulse reset: rst low during HIGH -> step=0 and count_N=0 immediately, without waiting for a clock edge.
